// File: rtl/bldc_pkg.sv
// rtl/bldc_pkg.sv - shared state encodings, duty width and six-step commutation table
package bldc_pkg;

  localparam int DUTY_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RAMP  = 2'b01;
  localparam logic [1:0] ST_RUN   = 2'b10;
  localparam logic [1:0] ST_FAULT = 2'b11;

  typedef struct packed {
    logic [2:0] hi;
    logic [2:0] lo;
  } gate_pair_t;

  // Forward rotation order; bit 0 = phase A, bit 2 = phase C
  localparam logic [2:0] HALL_SEQ [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
  localparam gate_pair_t COMM_TABLE [6] = '{
    '{hi: 3'b001, lo: 3'b010},
    '{hi: 3'b001, lo: 3'b100},
    '{hi: 3'b010, lo: 3'b100},
    '{hi: 3'b010, lo: 3'b001},
    '{hi: 3'b100, lo: 3'b001},
    '{hi: 3'b100, lo: 3'b010}
  };

  // Invalid codes (000/111) map to all gates off; reverse swaps the high and low sides
  function automatic gate_pair_t comm_lookup(input logic [2:0] code, input logic dir);
    gate_pair_t r;
    r = '{hi: 3'b000, lo: 3'b000};
    for (int i = 0; i < 6; i++) begin
      if (HALL_SEQ[i] == code) r = COMM_TABLE[i];
    end
    if (dir) r = '{hi: r.lo, lo: r.hi};
    return r;
  endfunction

endpackage

// File: rtl/bldc_hall_filter.sv
// rtl/bldc_hall_filter.sv - accepts a hall code after HALL_FILT identical samples, strobes on change
module bldc_hall_filter #(
  parameter int HALL_FILT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] hall,
  output logic [2:0] code,
  output logic       valid,
  output logic       chg
);

  localparam int CNT_W = $clog2(HALL_FILT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(HALL_FILT);

  logic [2:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       next_cand;
  logic [CNT_W-1:0] next_cnt;
  logic             accept;

  always_comb begin
    next_cand = cand;
    next_cnt  = cnt;
    if (hall != cand) begin
      next_cand = hall;
      next_cnt  = CNT_W'(1);
    end else if (cnt != CNT_FULL) begin
      next_cnt = cnt + CNT_W'(1);
    end
  end

  assign accept = (next_cnt == CNT_FULL);

  // valid stays low until some code has been seen HALL_FILT times, so the reset value is never acted on
  always_ff @(posedge clk) begin
    if (rst) begin
      cand  <= 3'b000;
      cnt   <= '0;
      code  <= 3'b000;
      valid <= 1'b0;
      chg   <= 1'b0;
    end else begin
      cand <= next_cand;
      cnt  <= next_cnt;
      chg  <= 1'b0;
      if (accept) begin
        valid <= 1'b1;
        if (next_cand != code) begin
          code <= next_cand;
          chg  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bldc_commutation_ctrl.sv
// rtl/bldc_commutation_ctrl.sv - six-step BLDC sequencer: soft start, dead time, hall fault
// Optional stall detection and STALL output enabled by defining STALL_DETECT_EN.
module bldc_commutation_ctrl
  import bldc_pkg::*;
#(
  parameter int DEADTIME  = 8,
  parameter int HALL_FILT = 4,
  parameter int RAMP_DIV  = 256
`ifdef STALL_DETECT_EN
  , parameter int STALL_TO = 1 << 20
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              DIR,
  input  logic [2:0]        HALL,
  input  logic [DUTY_W-1:0] DUTY_CMD,
  input  logic              PWM_IN,
  output logic [DUTY_W-1:0] DUTY_OUT,
  output logic              PWM_CE,
  output logic [2:0]        GATE_HI,
  output logic [2:0]        GATE_LO,
  output logic              FAULT,
  output logic [1:0]        STATE
`ifdef STALL_DETECT_EN
  , output logic            STALL
`endif
);

  localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DT_W   = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
  localparam logic [DT_W-1:0]   DT_LOAD   = DT_W'(DEADTIME - 1);

  logic [1:0]        state;
  logic [DUTY_W-1:0] duty_q;
  logic [RAMP_W-1:0] ramp_cnt;
  logic [DT_W-1:0]   dt_cnt;
  logic              dir_q;
  logic [2:0]        gate_hi_q;
  logic [2:0]        gate_lo_q;

  logic [2:0]        hall_code;
  logic              hall_valid;
  logic              hall_chg;
  logic              hall_bad;
  logic              active;
  logic              stall_hit;
  logic              go_fault;
  logic              ramp_tick;
  logic              gate_en;
  logic [DUTY_W-1:0] duty_up;
  gate_pair_t        pat;

  bldc_hall_filter #(.HALL_FILT(HALL_FILT)) u_hall_filter (
    .clk   (CLK),
    .rst   (RST),
    .hall  (HALL),
    .code  (hall_code),
    .valid (hall_valid),
    .chg   (hall_chg)
  );

  assign hall_bad  = hall_valid && ((hall_code == 3'b000) || (hall_code == 3'b111));
  assign active    = (state == ST_RAMP) || (state == ST_RUN);
  assign go_fault  = active && EN && (hall_bad || stall_hit);
  assign ramp_tick = (ramp_cnt == RAMP_LAST);
  assign duty_up   = (duty_q == '1) ? duty_q : duty_q + DUTY_W'(1);
  assign pat       = comm_lookup(hall_code, dir_q);
  // The change strobe blanks the gates itself; dt_cnt then covers the remaining DEADTIME-1 cycles
  assign gate_en   = active && EN && !go_fault && !hall_chg && (dt_cnt == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      duty_q    <= '0;
      ramp_cnt  <= '0;
      dt_cnt    <= '0;
      dir_q     <= 1'b0;
      gate_hi_q <= 3'b000;
      gate_lo_q <= 3'b000;
    end else begin
      if (hall_chg)            dt_cnt <= DT_LOAD;
      else if (dt_cnt != '0)   dt_cnt <= dt_cnt - DT_W'(1);

      gate_hi_q <= gate_en ? (pat.hi & {3{PWM_IN}}) : 3'b000;
      gate_lo_q <= gate_en ? pat.lo : 3'b000;

      case (state)
        ST_IDLE: begin
          dir_q    <= DIR;
          duty_q   <= '0;
          ramp_cnt <= '0;
          if (EN) state <= ST_RAMP;
        end
        ST_RAMP: begin
          if (!EN) begin
            state  <= ST_IDLE;
            duty_q <= '0;
          end else if (go_fault) begin
            state  <= ST_FAULT;
            duty_q <= '0;
          end else if (duty_q >= DUTY_CMD) begin
            state    <= ST_RUN;
            ramp_cnt <= '0;
          end else if (ramp_tick) begin
            duty_q   <= duty_up;
            ramp_cnt <= '0;
          end else begin
            ramp_cnt <= ramp_cnt + RAMP_W'(1);
          end
        end
        ST_RUN: begin
          if (!EN) begin
            state  <= ST_IDLE;
            duty_q <= '0;
          end else if (go_fault) begin
            state  <= ST_FAULT;
            duty_q <= '0;
          end else if (DUTY_CMD < duty_q) begin
            duty_q   <= DUTY_CMD;
            ramp_cnt <= '0;
          end else if (DUTY_CMD > duty_q) begin
            if (ramp_tick) begin
              duty_q   <= duty_up;
              ramp_cnt <= '0;
            end else begin
              ramp_cnt <= ramp_cnt + RAMP_W'(1);
            end
          end else begin
            ramp_cnt <= '0;
          end
        end
        default: begin
          duty_q   <= '0;
          ramp_cnt <= '0;
          if (!EN) state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef STALL_DETECT_EN
  localparam int STALL_W = $clog2(STALL_TO + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_TO);

  logic [STALL_W-1:0] stall_cnt;
  logic               stall_q;

  assign stall_hit = (state == ST_RUN) && (stall_cnt == STALL_MAX);

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      stall_q   <= 1'b0;
    end else begin
      if (hall_chg || ((state == ST_IDLE) && EN)) stall_cnt <= '0;
      else if (active && (stall_cnt != STALL_MAX)) stall_cnt <= stall_cnt + STALL_W'(1);

      if (go_fault)                           stall_q <= stall_hit;
      else if ((state == ST_FAULT) && !EN)    stall_q <= 1'b0;
    end
  end

  assign STALL = stall_q;
`else
  assign stall_hit = 1'b0;
`endif

  assign DUTY_OUT = duty_q;
  assign PWM_CE   = active;
  assign GATE_HI  = gate_hi_q;
  assign GATE_LO  = gate_lo_q;
  assign FAULT    = (state == ST_FAULT);
  assign STATE    = state;

endmodule

// File: tb/tb_bldc_commutation_ctrl.sv
// tb/tb_bldc_commutation_ctrl.sv - directed self-checking bench for bldc_commutation_ctrl
module tb_bldc_commutation_ctrl;

  logic       CLK = 1'b0;
  logic       RST, EN, DIR, PWM_IN;
  logic [2:0] HALL;
  logic [3:0] DUTY_CMD;
  logic [3:0] DUTY_OUT;
  logic       PWM_CE, FAULT;
  logic [2:0] GATE_HI, GATE_LO;
  logic [1:0] STATE;
`ifdef STALL_DETECT_EN
  logic       STALL;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] walk_code [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
  logic [2:0] walk_hi   [6] = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
  logic [2:0] walk_lo   [6] = '{3'b100, 3'b100, 3'b001, 3'b001, 3'b010, 3'b010};

  bldc_commutation_ctrl #(
    .DEADTIME (8),
    .HALL_FILT(4),
    .RAMP_DIV (4)
`ifdef STALL_DETECT_EN
    , .STALL_TO(64)
`endif
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .DIR     (DIR),
    .HALL    (HALL),
    .DUTY_CMD(DUTY_CMD),
    .PWM_IN  (PWM_IN),
    .DUTY_OUT(DUTY_OUT),
    .PWM_CE  (PWM_CE),
    .GATE_HI (GATE_HI),
    .GATE_LO (GATE_LO),
    .FAULT   (FAULT),
    .STATE   (STATE)
`ifdef STALL_DETECT_EN
    , .STALL (STALL)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1; EN = 1'b1; DIR = 1'b0; HALL = 3'b101; DUTY_CMD = 4'd6; PWM_IN = 1'b1;
    step(2);
    n_checks++; if (STATE !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", STATE); end
    n_checks++; if (DUTY_OUT !== 4'd0) begin n_fail++; $display("FAIL reset_duty: got %0d expected 0", DUTY_OUT); end
    n_checks++; if (PWM_CE !== 1'b0) begin n_fail++; $display("FAIL reset_ce: got %0b expected 0", PWM_CE); end
    n_checks++; if (GATE_HI !== 3'b000 || GATE_LO !== 3'b000) begin n_fail++; $display("FAIL reset_gates: got hi=%b lo=%b expected 000/000", GATE_HI, GATE_LO); end
    n_checks++; if (FAULT !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %0b expected 0", FAULT); end
  endtask

  task automatic test_ramp;
    RST = 1'b0;
    step(1);
    n_checks++; if (STATE !== 2'b01) begin n_fail++; $display("FAIL ramp_enter: got %0d expected 1", STATE); end
    n_checks++; if (PWM_CE !== 1'b1) begin n_fail++; $display("FAIL ramp_ce: got %0b expected 1", PWM_CE); end
    for (int k = 1; k <= 6; k++) begin
      step(3);
      n_checks++; if (DUTY_OUT !== 4'(k - 1)) begin n_fail++; $display("FAIL ramp_hold_%0d: got %0d expected %0d", k, DUTY_OUT, k - 1); end
      step(1);
      n_checks++; if (DUTY_OUT !== 4'(k)) begin n_fail++; $display("FAIL ramp_step_%0d: got %0d expected %0d", k, DUTY_OUT, k); end
    end
    step(1);
    n_checks++; if (STATE !== 2'b10) begin n_fail++; $display("FAIL ramp_to_run: got %0d expected 2", STATE); end
  endtask

  task automatic test_commutation;
    logic [2:0] prev_hi, prev_lo;
    n_checks++; if (GATE_HI !== 3'b001 || GATE_LO !== 3'b010) begin n_fail++; $display("FAIL comm_101: got hi=%b lo=%b expected 001/010", GATE_HI, GATE_LO); end
    PWM_IN = 1'b0;
    #1;
    n_checks++; if (GATE_HI !== 3'b001) begin n_fail++; $display("FAIL pwm_registered: got %b expected 001", GATE_HI); end
    step(1);
    n_checks++; if (GATE_HI !== 3'b000 || GATE_LO !== 3'b010) begin n_fail++; $display("FAIL pwm_low: got hi=%b lo=%b expected 000/010", GATE_HI, GATE_LO); end
    PWM_IN = 1'b1;
    step(1);
    n_checks++; if (GATE_HI !== 3'b001) begin n_fail++; $display("FAIL pwm_high: got %b expected 001", GATE_HI); end
    prev_hi = 3'b001; prev_lo = 3'b010;
    for (int i = 0; i < 6; i++) begin
      HALL = walk_code[i];
      step(4);
      n_checks++; if (GATE_HI !== prev_hi || GATE_LO !== prev_lo) begin n_fail++; $display("FAIL walk_old_%0d: got hi=%b lo=%b expected %b/%b", i, GATE_HI, GATE_LO, prev_hi, prev_lo); end
      for (int j = 0; j < 8; j++) begin
        step(1);
        n_checks++; if (GATE_HI !== 3'b000 || GATE_LO !== 3'b000) begin n_fail++; $display("FAIL deadtime_%0d_%0d: got hi=%b lo=%b expected 000/000", i, j, GATE_HI, GATE_LO); end
      end
      step(1);
      n_checks++; if (GATE_HI !== walk_hi[i] || GATE_LO !== walk_lo[i]) begin n_fail++; $display("FAIL walk_new_%0d: got hi=%b lo=%b expected %b/%b", i, GATE_HI, GATE_LO, walk_hi[i], walk_lo[i]); end
      n_checks++; if ((GATE_HI & GATE_LO) !== 3'b000) begin n_fail++; $display("FAIL shoot_through_%0d: got %b expected 000", i, GATE_HI & GATE_LO); end
      prev_hi = walk_hi[i]; prev_lo = walk_lo[i];
    end
  endtask

  task automatic test_glitch;
    HALL = 3'b100;
    step(2);
    HALL = 3'b101;
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_checks++; if (GATE_HI !== 3'b001 || GATE_LO !== 3'b010) begin n_fail++; $display("FAIL glitch_%0d: got hi=%b lo=%b expected 001/010", i, GATE_HI, GATE_LO); end
    end
  endtask

  task automatic test_invalid_hall;
    HALL = 3'b111;
    step(4);
    n_checks++; if (STATE !== 2'b10) begin n_fail++; $display("FAIL invalid_pre: got %0d expected 2", STATE); end
    step(1);
    n_checks++; if (STATE !== 2'b11 || FAULT !== 1'b1) begin n_fail++; $display("FAIL invalid_fault: got state=%0d fault=%0b expected 3/1", STATE, FAULT); end
    n_checks++; if (GATE_HI !== 3'b000 || GATE_LO !== 3'b000) begin n_fail++; $display("FAIL fault_gates: got hi=%b lo=%b expected 000/000", GATE_HI, GATE_LO); end
    n_checks++; if (DUTY_OUT !== 4'd0 || PWM_CE !== 1'b0) begin n_fail++; $display("FAIL fault_duty: got duty=%0d ce=%0b expected 0/0", DUTY_OUT, PWM_CE); end
    EN = 1'b0;
    step(1);
    n_checks++; if (STATE !== 2'b00 || FAULT !== 1'b0) begin n_fail++; $display("FAIL fault_clear: got state=%0d fault=%0b expected 0/0", STATE, FAULT); end
  endtask

  task automatic test_duty_track;
    HALL = 3'b101;
    step(5);
    EN = 1'b1; DUTY_CMD = 4'd0;
    step(2);
    n_checks++; if (STATE !== 2'b10 || DUTY_OUT !== 4'd0) begin n_fail++; $display("FAIL zero_cmd_run: got state=%0d duty=%0d expected 2/0", STATE, DUTY_OUT); end
    DUTY_CMD = 4'd15;
    step(30);
    HALL = 3'b100;
    step(29);
    n_checks++; if (DUTY_OUT !== 4'd14 || STATE !== 2'b10) begin n_fail++; $display("FAIL run_ramp_14: got duty=%0d state=%0d expected 14/2", DUTY_OUT, STATE); end
    step(1);
    n_checks++; if (DUTY_OUT !== 4'd15) begin n_fail++; $display("FAIL run_ramp_15: got %0d expected 15", DUTY_OUT); end
    step(3);
    n_checks++; if (DUTY_OUT !== 4'd15) begin n_fail++; $display("FAIL duty_saturate: got %0d expected 15", DUTY_OUT); end
    DUTY_CMD = 4'd3;
    step(1);
    n_checks++; if (DUTY_OUT !== 4'd3) begin n_fail++; $display("FAIL duty_drop: got %0d expected 3", DUTY_OUT); end
  endtask

  task automatic test_reverse;
    EN = 1'b0;
    step(1);
    n_checks++; if (STATE !== 2'b00 || DUTY_OUT !== 4'd0 || GATE_LO !== 3'b000) begin n_fail++; $display("FAIL en_off: got state=%0d duty=%0d lo=%b expected 0/0/000", STATE, DUTY_OUT, GATE_LO); end
    DIR = 1'b1; EN = 1'b1; DUTY_CMD = 4'd3;
    step(2);
    n_checks++; if (GATE_HI !== 3'b100 || GATE_LO !== 3'b001) begin n_fail++; $display("FAIL reverse_100: got hi=%b lo=%b expected 100/001", GATE_HI, GATE_LO); end
    DIR = 1'b0;
    step(1);
    n_checks++; if (GATE_HI !== 3'b100 || GATE_LO !== 3'b001) begin n_fail++; $display("FAIL dir_latched: got hi=%b lo=%b expected 100/001", GATE_HI, GATE_LO); end
  endtask

  task automatic test_stall;
    EN = 1'b0;
    step(1);
    EN = 1'b1; DUTY_CMD = 4'd0;
`ifdef STALL_DETECT_EN
    step(65);
    n_checks++; if (STATE !== 2'b10) begin n_fail++; $display("FAIL stall_pre: got %0d expected 2", STATE); end
    step(1);
    n_checks++; if (STATE !== 2'b11 || FAULT !== 1'b1 || STALL !== 1'b1) begin n_fail++; $display("FAIL stall_fault: got state=%0d fault=%0b stall=%0b expected 3/1/1", STATE, FAULT, STALL); end
    EN = 1'b0;
    step(1);
    n_checks++; if (STALL !== 1'b0 || FAULT !== 1'b0) begin n_fail++; $display("FAIL stall_clear: got stall=%0b fault=%0b expected 0/0", STALL, FAULT); end
`else
    step(200);
    n_checks++; if (STATE !== 2'b10 || FAULT !== 1'b0) begin n_fail++; $display("FAIL stopped_rotor: got state=%0d fault=%0b expected 2/0", STATE, FAULT); end
    n_checks++; if (GATE_HI !== 3'b001 || GATE_LO !== 3'b100) begin n_fail++; $display("FAIL stopped_hold: got hi=%b lo=%b expected 001/100", GATE_HI, GATE_LO); end
`endif
  endtask

  task automatic test_reset_mid;
    EN = 1'b1; DUTY_CMD = 4'd2;
    step(3);
    RST = 1'b1;
    step(1);
    n_checks++; if (STATE !== 2'b00 || DUTY_OUT !== 4'd0 || PWM_CE !== 1'b0 || FAULT !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got state=%0d duty=%0d ce=%0b fault=%0b expected 0/0/0/0", STATE, DUTY_OUT, PWM_CE, FAULT); end
    n_checks++; if (GATE_HI !== 3'b000 || GATE_LO !== 3'b000) begin n_fail++; $display("FAIL mid_reset_gates: got hi=%b lo=%b expected 000/000", GATE_HI, GATE_LO); end
  endtask

  initial begin
    test_reset;
    test_ramp;
    test_commutation;
    test_glitch;
    test_invalid_hall;
    test_duty_track;
    test_reverse;
    test_stall;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
